l1_icache: RTL and testbench
============================

L1_ICACHE -- requirements
Module: l1_icache

Interface
REQ-001 Parameter ADDR_W, default 16, word address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter INDEX_W, default 6, log2 line count (64 lines).
REQ-004 Parameter OFFSET_W, default 2, log2 words per line (4 words); tag width = ADDR_W-INDEX_W-OFFSET_W.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clk_en  input  1  global advance enable; when low all state, including memory-side beats, holds.
REQ-008 read_req  input  1  fetch request, sampled when clk_en high.
REQ-009 read_addr  input  ADDR_W  fetch word address.
REQ-010 flush  input  1  invalidate all lines.
REQ-011 read_data  output  DATA_W  fetched word, valid when data_ready high.
REQ-012 data_ready  output  1  one-cycle pulse per completed fetch.
REQ-013 busy  output  1  high in any state except IDLE; read_req ignored while high.
REQ-014 mem_req  output  1  refill request, held high until last beat accepted.
REQ-015 mem_addr  output  ADDR_W  line-aligned refill address (offset bits zero), stable while mem_req high.
REQ-016 mem_valid  input  1  refill beat strobe.
REQ-017 mem_data  input  DATA_W  refill beat data; beats arrive in offset order 0..2^OFFSET_W-1.
REQ-018 miss_count  output  16  saturating count of misses.

Function
REQ-019 Direct-mapped, read-only; per line: valid bit, tag, 2^OFFSET_W data words.
REQ-020 States: IDLE, REFILL, RESPOND.
REQ-021 IDLE, read_req, hit: read_data = stored word, data_ready=1 on the next edge (1-cycle latency); state stays IDLE.
REQ-022 IDLE, read_req, miss: capture address, increment miss_count (saturate at 0xFFFF), go REFILL; mem_req and mem_addr asserted from the next cycle.
REQ-023 REFILL: each mem_valid beat writes the word at the beat counter offset; the counter wraps to zero after the last beat.
REQ-024 REFILL: on the last beat, set valid and tag, drop mem_req on the next edge, go RESPOND.
REQ-025 RESPOND: read_data = captured-offset word, data_ready=1 for one cycle, then IDLE.
REQ-026 data_ready is 0 in every cycle not named in REQ-021/REQ-025; read_data holds its last value.
REQ-027 flush in IDLE clears all valid bits on the next edge; flush wins over a simultaneous read_req, which is dropped with no data_ready.
REQ-028 flush in REFILL/RESPOND sets a pending flag; the refill completes and responds normally, then all valid bits (including the new line) clear in the first IDLE cycle.
REQ-029 mem_valid outside REFILL is ignored.
REQ-030 clk_en low: no state, counter, storage or output change; a pending data_ready pulse extends until clk_en returns high.

Reset
REQ-031 rst sampled high: state IDLE, all valid bits 0, pending flush 0, beat counter 0, miss_count 0, read_data 0, data_ready 0, mem_req 0, mem_addr 0; data array contents need not clear.
REQ-032 rst overrides clk_en and aborts a refill in progress; mem_req is 0 from the cycle after rst is sampled, with no data_ready.

Structure
REQ-033 Package l1_cache_pkg holds the state enumeration and the default parameter values.
REQ-034 Tag/valid/data storage is a sub-module l1_cache_store (one read port, one write port, bulk valid clear); the FSM stays in l1_icache.

Verification
REQ-035 Reset, then read_req addr 0x0010 -> miss, mem_addr 0x0010, four beats 0xA0..0xA3 -> data_ready with read_data 0xA0; miss_count 1.
REQ-036 Then read_req 0x0013 -> data_ready one cycle later with 0xA3, no mem_req; miss_count 1.
REQ-037 read_req 0x0410 (same index, new tag) -> miss, refill beats 0xB0..0xB3 -> 0xB0; re-read 0x0010 -> miss again; miss_count 3.
REQ-038 flush during REFILL beat 2 -> refill completes and returns the word, then re-read of the same address misses.
REQ-039 clk_en low for 3 cycles between beats 1 and 2, with mem_valid high -> beats not consumed; final data correct.
REQ-040 rst mid-REFILL -> mem_req 0 next cycle, no data_ready; re-read of the same address misses, miss_count 1.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared definitions for the L1 instruction cache: controller states and
// default geometry.
package l1_cache_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int INDEX_W_DEF  = 6;
  localparam int OFFSET_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/l1_cache_store.sv
// Direct-mapped line storage: valid bits, tags and data words.
// It has one combinational read port, one word write port and a bulk valid clear.
module l1_cache_store
  import l1_cache_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int TAG_W    = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [DATA_W-1:0]   rd_data,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                tag_set,
  input  logic [TAG_W-1:0]    tag_val,
  input  logic                clear_all
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [WORDS];

  assign rd_data  = data_mem[{rd_index, rd_offset}];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];

  // Clear and set never coincide: clears happen in IDLE, sets only at the end of a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (tag_set) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_set) begin
      tag_mem[wr_index] <= tag_val;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
  end

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped, read-only L1 instruction cache controller.
// Hits take one cycle. A miss refills the whole line and then answers with the requested word.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | accept lookups; hits answer next cycle; flushes apply
// ST_REFILL  | mem_req high, consume line beats in offset order
// ST_RESPOND | line written; return captured word, then back to IDLE
module l1_icache
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] read_data,
  output logic              data_ready,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [15:0]       miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]   cap_addr_q;
  logic [OFFSET_W-1:0] beat_q;
  logic                flush_pend_q;

  logic [INDEX_W-1:0]  rd_index;
  logic [OFFSET_W-1:0] rd_offset;
  logic [DATA_W-1:0]   rd_data;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;

  logic [TAG_W-1:0]    req_tag;
  logic [TAG_W-1:0]    cap_tag;
  logic [INDEX_W-1:0]  cap_index;

  logic lookup, hit, miss_go, beat_go, last_beat, do_clear, tag_set;

  assign req_tag   = read_addr[ADDR_W-1 -: TAG_W];
  assign cap_tag   = cap_addr_q[ADDR_W-1 -: TAG_W];
  assign cap_index = cap_addr_q[OFFSET_W +: INDEX_W];

  l1_cache_store #(
    .DATA_W   (DATA_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (rd_index),
    .rd_offset (rd_offset),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (beat_go),
    .wr_index  (cap_index),
    .wr_offset (beat_q),
    .wr_data   (mem_data),
    .tag_set   (tag_set),
    .tag_val   (cap_tag),
    .clear_all (do_clear)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (miss_go)   state_d = ST_REFILL;
      ST_REFILL:  if (last_beat) state_d = ST_RESPOND;
      ST_RESPOND:                state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // A pending flush makes every lookup miss, because the line just filled is about to be invalidated.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    rd_index  = read_addr[OFFSET_W +: INDEX_W];
    rd_offset = read_addr[OFFSET_W-1:0];
    if (state_q != ST_IDLE) begin
      rd_index  = cap_index;
      rd_offset = cap_addr_q[OFFSET_W-1:0];
    end
    lookup    = clk_en && (state_q == ST_IDLE) && read_req && !flush;
    hit       = lookup && rd_valid && (rd_tag == req_tag) && !flush_pend_q;
    miss_go   = lookup && !hit;
    beat_go   = clk_en && (state_q == ST_REFILL) && mem_valid;
    last_beat = beat_go && (beat_q == LAST_BEAT);
    tag_set   = last_beat;
    do_clear  = clk_en && (state_q == ST_IDLE) && (flush || flush_pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_addr_q   <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      read_data    <= '0;
      data_ready   <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      miss_count   <= '0;
    end else if (clk_en) begin
      data_ready <= 1'b0;
      if (hit || (state_q == ST_RESPOND)) begin
        read_data  <= rd_data;
        data_ready <= 1'b1;
      end
      if (miss_go) begin
        cap_addr_q <= read_addr;
        mem_addr   <= {read_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        mem_req    <= 1'b1;
        if (miss_count != 16'hFFFF) begin
          miss_count <= miss_count + 16'd1;
        end
      end
      if (beat_go) begin
        beat_q <= beat_q + 1'b1;
      end
      if (last_beat) begin
        mem_req <= 1'b0;
      end
      if ((state_q != ST_IDLE) && flush) begin
        flush_pend_q <= 1'b1;
      end else if (do_clear) begin
        flush_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache. Expected fetch words go into a queue, and a negedge monitor
// pops the queue and compares on every data_ready pulse the cache consumes.
module tb_l1_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        read_req = 1'b0;
  logic [15:0] read_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] read_data;
  logic        data_ready;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  l1_icache dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .read_req   (read_req),
    .read_addr  (read_addr),
    .flush      (flush),
    .read_data  (read_data),
    .data_ready (data_ready),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A pulse counts only when clk_en is high, because the pulse is held while clk_en is low.
  always @(negedge clk) begin
    if (!rst && clk_en && data_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got read_data 0x%0h expected no pulse", read_data);
      end else begin
        check("read_data", read_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] addr);
    read_req  = 1'b1;
    read_addr = addr;
    tick();
    read_req  = 1'b0;
  endtask

  task automatic wait_mem_req(output bit ok);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    ok = mem_req;
    check("mem_req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic refill(input logic [15:0] addr, input logic [31:0] base,
                        input bit flush_b2, input bit stall_b2);
    bit ok;
    wait_mem_req(ok);
    if (ok) begin
      check("mem_addr", {16'd0, mem_addr}, {16'd0, addr & 16'hFFFC});
      for (int i = 0; i < 4; i++) begin
        if (i == 2 && stall_b2) begin
          clk_en    = 1'b0;
          mem_valid = 1'b1;
          mem_data  = 32'hDEAD_BEEF;
          repeat (3) tick();
          check("stall_mem_req", {31'd0, mem_req}, 32'd1);
          clk_en = 1'b1;
        end
        mem_valid = 1'b1;
        mem_data  = base + i;
        flush     = (i == 2) && flush_b2;
        tick();
        flush = 1'b0;
      end
      mem_valid = 1'b0;
      check("mem_req_drop", {31'd0, mem_req}, 32'd0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  task automatic miss_read(input logic [15:0] addr, input logic [31:0] base,
                           input bit flush_b2, input bit stall_b2);
    exp_q.push_back(base + {30'd0, addr[1:0]});
    do_read(addr);
    refill(addr, base, flush_b2, stall_b2);
    wait_drain();
  endtask

  task automatic hit_read(input logic [15:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    do_read(addr);
    check("hit_mem_req", {31'd0, mem_req}, 32'd0);
    check("hit_busy", {31'd0, busy}, 32'd0);
    wait_drain();
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_miss_count", {16'd0, miss_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    miss_read(16'h0010, 32'hA0, 1'b0, 1'b0);
    check("miss_count_1", {16'd0, miss_count}, 32'd1);
    hit_read(16'h0013, 32'hA3);
    check("miss_count_hit", {16'd0, miss_count}, 32'd1);

    miss_read(16'h0410, 32'hB0, 1'b0, 1'b0);
    miss_read(16'h0010, 32'hC0, 1'b0, 1'b0);
    check("miss_count_3", {16'd0, miss_count}, 32'd3);

    // flush during beat 2: the word still returns, then the line (and its neighbours) must miss
    miss_read(16'h0021, 32'hD0, 1'b1, 1'b0);
    miss_read(16'h0021, 32'hE0, 1'b0, 1'b0);
    miss_read(16'h0012, 32'hF0, 1'b0, 1'b0);
    check("miss_count_6", {16'd0, miss_count}, 32'd6);

    miss_read(16'h0030, 32'h50, 1'b0, 1'b1);
    hit_read(16'h0032, 32'h52);
    check("miss_count_7", {16'd0, miss_count}, 32'd7);

    // reset in the middle of a refill
    do_read(16'h0040);
    wait_mem_req(ok);
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1;
      mem_data  = 32'h60 + i;
      tick();
    end
    mem_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_ready", {31'd0, data_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();

    // flush beats a simultaneous read_req in IDLE
    flush     = 1'b1;
    read_req  = 1'b1;
    read_addr = 16'h0040;
    tick();
    flush    = 1'b0;
    read_req = 1'b0;
    tick();
    check("flush_drop_mem_req", {31'd0, mem_req}, 32'd0);
    check("flush_drop_busy", {31'd0, busy}, 32'd0);
    check("flush_drop_miss", {16'd0, miss_count}, 32'd0);

    miss_read(16'h0040, 32'h70, 1'b0, 1'b0);
    check("miss_count_after_rst", {16'd0, miss_count}, 32'd1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
